// File: rtl/layer_sequencer_if.sv
// Bundle of job-control, GLB, array and PPU handshake signals for layer_sequencer.
// master = the sequencer itself, slave = the surrounding datapath / environment.
interface layer_sequencer_if #(
    parameter int WIDTH       = 64,
    parameter int ARRAY_TIMES = 16,
    parameter int ADDR_W      = 12,
    parameter int TILE_W      = 8
);
    localparam int STG_W = $clog2(ARRAY_TIMES);
    localparam int PPU_W = $clog2(WIDTH + 1);

    logic              start;
    logic              mode;
    logic [TILE_W-1:0] num_tiles;
    logic              glb_ready;
    logic              ifmap_wen;
    logic              weight_wen;
    logic              bias_wen;
    logic              ifmap_ren;
    logic              weight_ren;
    logic              bias_ren;
    logic              ofmap_ren;
    logic [ADDR_W-1:0] data_address;
    logic              i_en_array;
    logic              valid_array;
    logic [STG_W-1:0]  compute_stage;
    logic              i_en_ppu;
    logic              valid_ppu;
    logic [PPU_W-1:0]  ppu_count;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;

    modport master (
        input  start, mode, num_tiles, glb_ready, valid_array, valid_ppu,
        output ifmap_wen, weight_wen, bias_wen, ifmap_ren, weight_ren, bias_ren,
               ofmap_ren, data_address, i_en_array, compute_stage, i_en_ppu,
               ppu_count, tile_idx, busy, done
    );

    modport slave (
        output start, mode, num_tiles, glb_ready, valid_array, valid_ppu,
        input  ifmap_wen, weight_wen, bias_wen, ifmap_ren, weight_ren, bias_ren,
               ofmap_ren, data_address, i_en_array, compute_stage, i_en_ppu,
               ppu_count, tile_idx, busy, done
    );
endinterface

// File: rtl/layer_sequencer.sv
// Per-tile layer controller: loads ifmap/weight/bias into the GLB, runs ARRAY_TIMES
// array passes, drains WIDTH ofmap words through the PPU, then advances to the next tile.
module layer_sequencer #(
    parameter int WIDTH       = 64,
    parameter int ARRAY_TIMES = 16,
    parameter int ADDR_W      = 12,
    parameter int TILE_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.master  bus
);
    localparam int IFMAP_WORDS  = WIDTH / 4;
    localparam int WEIGHT_WORDS = WIDTH * WIDTH / 4;
    localparam int BIAS_WORDS   = WIDTH;
    localparam int STG_W        = $clog2(ARRAY_TIMES);
    localparam int PPU_W        = $clog2(WIDTH + 1);

    localparam logic [ADDR_W-1:0] IFMAP_LAST  = ADDR_W'(IFMAP_WORDS - 1);
    localparam logic [ADDR_W-1:0] WEIGHT_LAST = ADDR_W'(WEIGHT_WORDS - 1);
    localparam logic [ADDR_W-1:0] BIAS_LAST   = ADDR_W'(BIAS_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFMAP_LAST  = ADDR_W'(WIDTH - 1);
    localparam logic [STG_W-1:0]  STAGE_LAST  = STG_W'(ARRAY_TIMES - 1);
    localparam logic [PPU_W-1:0]  BEAT_LAST   = PPU_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, LD_IFMAP, LD_WEIGHT, LD_BIAS, ARRAY, PPU, NEXT_TILE, DONE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [STG_W-1:0]  stage_reg;
    logic [PPU_W-1:0]  beat_reg;
    logic [TILE_W-1:0] tile_reg;
    logic [TILE_W-1:0] tiles_reg;
    logic              mode_reg;
    logic              en_array_reg;
    logic              en_ppu_reg;
    logic              rd_done_reg;

    logic [ADDR_W-1:0] load_last;
    state_t            load_next;
    logic              ofmap_ren;
    logic              tile_last;

    // The three load states share one address walker; only the length and successor differ.
    always_comb begin
        load_last = IFMAP_LAST;
        load_next = LD_WEIGHT;
        case (state_reg)
            LD_IFMAP: begin
                load_last = IFMAP_LAST;
                load_next = (mode_reg && (tile_reg != '0)) ? ARRAY : LD_WEIGHT;
            end
            LD_WEIGHT: begin
                load_last = WEIGHT_LAST;
                load_next = LD_BIAS;
            end
            LD_BIAS: begin
                load_last = BIAS_LAST;
                load_next = ARRAY;
            end
            default: ;
        endcase
    end

    assign ofmap_ren = (state_reg == PPU) && !rd_done_reg;
    assign tile_last = (tile_reg == (tiles_reg - TILE_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            stage_reg    <= '0;
            beat_reg     <= '0;
            tile_reg     <= '0;
            tiles_reg    <= '0;
            mode_reg     <= 1'b0;
            en_array_reg <= 1'b0;
            en_ppu_reg   <= 1'b0;
            rd_done_reg  <= 1'b0;
        end else begin
            en_array_reg <= 1'b0;
            en_ppu_reg   <= ofmap_ren;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_reg <= LD_IFMAP;
                        addr_reg  <= '0;
                        tile_reg  <= '0;
                        mode_reg  <= bus.mode;
                        tiles_reg <= (bus.num_tiles == '0) ? TILE_W'(1) : bus.num_tiles;
                    end
                end
                LD_IFMAP, LD_WEIGHT, LD_BIAS: begin
                    if (bus.glb_ready) begin
                        if (addr_reg == load_last) begin
                            addr_reg  <= '0;
                            state_reg <= load_next;
                            if (load_next == ARRAY) begin
                                stage_reg    <= '0;
                                en_array_reg <= 1'b1;
                            end
                        end else begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                        end
                    end
                end
                ARRAY: begin
                    if (bus.valid_array) begin
                        if (stage_reg == STAGE_LAST) begin
                            stage_reg   <= '0;
                            addr_reg    <= '0;
                            rd_done_reg <= 1'b0;
                            state_reg   <= PPU;
                        end else begin
                            stage_reg    <= stage_reg + STG_W'(1);
                            addr_reg     <= ADDR_W'(stage_reg) + ADDR_W'(1);
                            en_array_reg <= 1'b1;
                        end
                    end
                end
                PPU: begin
                    // Read WIDTH ofmap words once; the address parks on the last word.
                    if (!rd_done_reg) begin
                        if (addr_reg == OFMAP_LAST) begin
                            rd_done_reg <= 1'b1;
                        end else begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                        end
                    end
                    if (bus.valid_ppu) begin
                        if (beat_reg == BEAT_LAST) begin
                            beat_reg    <= '0;
                            addr_reg    <= '0;
                            rd_done_reg <= 1'b0;
                            state_reg   <= NEXT_TILE;
                        end else begin
                            beat_reg <= beat_reg + PPU_W'(1);
                        end
                    end
                end
                NEXT_TILE: begin
                    addr_reg <= '0;
                    if (tile_last) begin
                        state_reg <= DONE;
                    end else begin
                        tile_reg  <= tile_reg + TILE_W'(1);
                        state_reg <= LD_IFMAP;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ifmap_wen     = (state_reg == LD_IFMAP) && bus.glb_ready;
    assign bus.weight_wen    = (state_reg == LD_WEIGHT) && bus.glb_ready;
    assign bus.bias_wen      = (state_reg == LD_BIAS) && bus.glb_ready;
    assign bus.ifmap_ren     = (state_reg == ARRAY);
    assign bus.weight_ren    = (state_reg == ARRAY);
    assign bus.bias_ren      = (state_reg == ARRAY);
    assign bus.ofmap_ren     = ofmap_ren;
    assign bus.data_address  = addr_reg;
    assign bus.i_en_array    = en_array_reg;
    assign bus.compute_stage = stage_reg;
    assign bus.i_en_ppu      = en_ppu_reg;
    assign bus.ppu_count     = beat_reg;
    assign bus.tile_idx      = tile_reg;
    assign bus.busy          = (state_reg != IDLE) && (state_reg != DONE);
    assign bus.done          = (state_reg == DONE);
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (WIDTH=8, ARRAY_TIMES=4) with simple array/PPU
// responders; expected counts and cycle numbers are worked out by hand below.
module tb_layer_sequencer;
    localparam int WIDTH       = 8;
    localparam int ARRAY_TIMES = 4;
    localparam int ADDR_W      = 12;
    localparam int TILE_W      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_sequencer_if #(.WIDTH(WIDTH), .ARRAY_TIMES(ARRAY_TIMES), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) bus ();

    layer_sequencer #(.WIDTH(WIDTH), .ARRAY_TIMES(ARRAY_TIMES), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Array answers 4 cycles after each pass start; PPU echoes i_en_ppu one cycle later.
    logic       arr_resp, ppu_resp, force_va, force_vp;
    logic [1:0] arr_cnt;
    assign bus.valid_array = arr_resp | force_va;
    assign bus.valid_ppu   = ppu_resp | force_vp;

    always @(posedge clk) begin
        if (rst) begin
            arr_cnt  <= 2'd0;
            arr_resp <= 1'b0;
            ppu_resp <= 1'b0;
        end else begin
            arr_resp <= 1'b0;
            ppu_resp <= bus.i_en_ppu;
            if (bus.i_en_array) begin
                arr_cnt <= 2'd3;
            end else if (arr_cnt != 2'd0) begin
                arr_cnt <= arr_cnt - 2'd1;
                if (arr_cnt == 2'd1) arr_resp <= 1'b1;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    int n_ifmap, n_weight, n_bias, n_arr, n_aren, n_ofmap, n_beats;
    int wb_late, addr_err, inj_err, first_arr, done_cyc, n_seen;
    int seq [8];
    bit timed_out;

    function automatic logic [10:0] strobes();
        return {bus.busy, bus.done, bus.ifmap_wen, bus.weight_wen, bus.bias_wen,
                bus.ifmap_ren, bus.weight_ren, bus.bias_ren, bus.ofmap_ren,
                bus.i_en_array, bus.i_en_ppu};
    endfunction

    // Drives one job from IDLE/DONE and gathers per-cycle statistics (cycle 1 = first LD_IFMAP cycle).
    task automatic run_job(input logic m, input logic [TILE_W-1:0] nt, input bit toggle, input bit inject);
        int  cyc;
        bit  fin;
        logic prev_ofmap;
        n_ifmap = 0; n_weight = 0; n_bias = 0; n_arr = 0; n_aren = 0; n_ofmap = 0; n_beats = 0;
        wb_late = 0; addr_err = 0; inj_err = 0; first_arr = -1; done_cyc = -1; n_seen = 0;
        fin = 1'b0; prev_ofmap = 1'b0; cyc = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = m; bus.num_tiles = nt; bus.glb_ready = 1'b1;
        while (!fin && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0; force_va = 1'b0; force_vp = 1'b0;
            if (toggle) bus.glb_ready = (cyc % 2 == 1);
            if (inject && (cyc % 3 == 0) && cyc <= 24) begin
                bus.start = 1'b1; bus.mode = ~m; bus.num_tiles = 8'd5;
                force_va = 1'b1; force_vp = 1'b1;
            end
            @(negedge clk);
            if (bus.ifmap_wen) begin
                if (bus.data_address !== ADDR_W'(n_ifmap % 2)) addr_err++;
                n_ifmap++;
            end
            if (bus.weight_wen) begin
                if (bus.data_address !== ADDR_W'(n_weight % 16)) addr_err++;
                if (bus.tile_idx !== '0) wb_late++;
                n_weight++;
            end
            if (bus.bias_wen) begin
                if (bus.data_address !== ADDR_W'(n_bias % 8)) addr_err++;
                if (bus.tile_idx !== '0) wb_late++;
                n_bias++;
            end
            if (bus.ifmap_ren) begin
                if (bus.data_address !== ADDR_W'(bus.compute_stage)) addr_err++;
                if (!(bus.weight_ren && bus.bias_ren)) addr_err++;
                n_aren++;
            end
            if (bus.i_en_array) begin
                if (bus.compute_stage !== 2'(n_arr % 4) || !bus.ifmap_ren) addr_err++;
                if (first_arr < 0) first_arr = cyc;
                n_arr++;
            end
            if (bus.ofmap_ren) begin
                if (bus.data_address !== ADDR_W'(n_ofmap % 8)) addr_err++;
                n_ofmap++;
            end
            if (bus.i_en_ppu !== prev_ofmap) addr_err++;
            prev_ofmap = bus.ofmap_ren;
            if (bus.valid_ppu && !force_vp && bus.busy) n_beats++;
            if (!bus.busy && (strobes() & 11'b00111111111) != '0) addr_err++;
            if (inject && cyc <= 26) begin
                if (!bus.busy || bus.compute_stage !== '0 || bus.ppu_count !== '0 || bus.tile_idx !== '0)
                    inj_err++;
            end
            if (bus.busy && (n_seen == 0 || int'(bus.tile_idx) != seq[n_seen-1]) && n_seen < 8) begin
                seq[n_seen] = int'(bus.tile_idx);
                n_seen++;
            end
            if (bus.done) begin
                fin = 1'b1;
                done_cyc = cyc;
            end
        end
        timed_out = !fin;
        bus.start = 1'b0; bus.glb_ready = 1'b1; force_va = 1'b0; force_vp = 1'b0;
        $display("job mode=%0d tiles=%0d: done_cyc=%0d ifmap=%0d weight=%0d bias=%0d arr=%0d ofmap=%0d beats=%0d",
                 m, nt, done_cyc, n_ifmap, n_weight, n_bias, n_arr, n_ofmap, n_beats);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (strobes() !== 11'd0) begin miscompares++; $display("FAIL reset/strobes got %b want 0", strobes()); end
        vectors++; if (bus.data_address !== '0) begin miscompares++; $display("FAIL reset/data_address got %0d want 0", bus.data_address); end
        vectors++; if (bus.compute_stage !== '0 || bus.ppu_count !== '0 || bus.tile_idx !== '0) begin
            miscompares++; $display("FAIL reset/counters got stage=%0d ppu=%0d tile=%0d want 0", bus.compute_stage, bus.ppu_count, bus.tile_idx); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (strobes() !== 11'd0) begin miscompares++; $display("FAIL reset/idle_after got %b want 0", strobes()); end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_single_tile();
        run_job(1'b0, 8'd1, 1'b0, 1'b0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL single/timeout got no done want done"); end
        vectors++; if (n_ifmap !== 2) begin miscompares++; $display("FAIL single/ifmap_wen got %0d want 2", n_ifmap); end
        vectors++; if (n_weight !== 16) begin miscompares++; $display("FAIL single/weight_wen got %0d want 16", n_weight); end
        vectors++; if (n_bias !== 8) begin miscompares++; $display("FAIL single/bias_wen got %0d want 8", n_bias); end
        vectors++; if (n_arr !== 4) begin miscompares++; $display("FAIL single/i_en_array got %0d want 4", n_arr); end
        vectors++; if (n_aren !== 20) begin miscompares++; $display("FAIL single/array_cycles got %0d want 20", n_aren); end
        vectors++; if (n_ofmap !== 8) begin miscompares++; $display("FAIL single/ofmap_ren got %0d want 8", n_ofmap); end
        vectors++; if (n_beats !== 8) begin miscompares++; $display("FAIL single/valid_ppu got %0d want 8", n_beats); end
        vectors++; if (first_arr !== 27) begin miscompares++; $display("FAIL single/first_i_en_array got %0d want 27", first_arr); end
        vectors++; if (done_cyc !== 58) begin miscompares++; $display("FAIL single/done_cycle got %0d want 58", done_cyc); end
        vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL single/per_cycle got %0d errors want 0", addr_err); end
        vectors++; if (bus.ppu_count !== '0 || bus.compute_stage !== '0) begin
            miscompares++; $display("FAIL single/cleared got ppu=%0d stage=%0d want 0", bus.ppu_count, bus.compute_stage); end
    endtask

    task automatic test_ready_stall();
        run_job(1'b0, 8'd1, 1'b1, 1'b0);
        vectors++; if (n_weight !== 16) begin miscompares++; $display("FAIL stall/weight_wen got %0d want 16", n_weight); end
        vectors++; if (n_ifmap !== 2 || n_bias !== 8) begin miscompares++; $display("FAIL stall/ifmap_bias got %0d,%0d want 2,8", n_ifmap, n_bias); end
        vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL stall/address got %0d errors want 0", addr_err); end
        vectors++; if (first_arr !== 52) begin miscompares++; $display("FAIL stall/first_i_en_array got %0d want 52", first_arr); end
        vectors++; if (done_cyc !== 83) begin miscompares++; $display("FAIL stall/done_cycle got %0d want 83", done_cyc); end
    endtask

    task automatic test_weight_reuse();
        run_job(1'b1, 8'd3, 1'b0, 1'b0);
        vectors++; if (n_weight !== 16 || n_bias !== 8) begin miscompares++; $display("FAIL reuse/weight_bias got %0d,%0d want 16,8", n_weight, n_bias); end
        vectors++; if (wb_late !== 0) begin miscompares++; $display("FAIL reuse/late_loads got %0d want 0", wb_late); end
        vectors++; if (n_ifmap !== 6 || n_arr !== 12 || n_ofmap !== 24) begin
            miscompares++; $display("FAIL reuse/counts got ifmap=%0d arr=%0d ofmap=%0d want 6,12,24", n_ifmap, n_arr, n_ofmap); end
        vectors++; if (n_seen !== 3 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 2) begin
            miscompares++; $display("FAIL reuse/tile_seq got n=%0d %0d,%0d,%0d want 3 0,1,2", n_seen, seq[0], seq[1], seq[2]); end
        vectors++; if (done_cyc !== 124) begin miscompares++; $display("FAIL reuse/done_cycle got %0d want 124", done_cyc); end
        vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL reuse/per_cycle got %0d errors want 0", addr_err); end
        repeat (5) @(negedge clk);
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.tile_idx !== 8'd2) begin
            miscompares++; $display("FAIL reuse/done_held got done=%0d busy=%0d tile=%0d want 1,0,2", bus.done, bus.busy, bus.tile_idx); end
    endtask

    task automatic test_zero_tiles();
        run_job(1'b0, 8'd0, 1'b0, 1'b0);
        vectors++; if (done_cyc !== 58) begin miscompares++; $display("FAIL zero/done_cycle got %0d want 58", done_cyc); end
        vectors++; if (n_seen !== 1 || n_ifmap !== 2 || n_weight !== 16 || n_arr !== 4) begin
            miscompares++; $display("FAIL zero/single_tile got tiles=%0d ifmap=%0d weight=%0d arr=%0d want 1,2,16,4", n_seen, n_ifmap, n_weight, n_arr); end
    endtask

    task automatic test_ignore_while_busy();
        run_job(1'b0, 8'd1, 1'b0, 1'b1);
        vectors++; if (inj_err !== 0) begin miscompares++; $display("FAIL ignore/load_state got %0d errors want 0", inj_err); end
        vectors++; if (done_cyc !== 58) begin miscompares++; $display("FAIL ignore/done_cycle got %0d want 58", done_cyc); end
        vectors++; if (n_weight !== 16 || n_arr !== 4 || n_seen !== 1) begin
            miscompares++; $display("FAIL ignore/counts got weight=%0d arr=%0d tiles=%0d want 16,4,1", n_weight, n_arr, n_seen); end
    endtask

    task automatic test_reset_mid_array();
        int  k;
        bit  hit;
        hit = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = 1'b0; bus.num_tiles = 8'd1; bus.glb_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (bus.ifmap_ren && bus.compute_stage == 2'd2) hit = 1'b1;
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL midrst/reach_stage2 got timeout want stage 2"); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (strobes() !== 11'd0) begin miscompares++; $display("FAIL midrst/strobes got %b want 0", strobes()); end
        vectors++; if (bus.data_address !== '0 || bus.compute_stage !== '0 || bus.ppu_count !== '0 || bus.tile_idx !== '0) begin
            miscompares++; $display("FAIL midrst/counters got addr=%0d stage=%0d ppu=%0d tile=%0d want 0",
                                     bus.data_address, bus.compute_stage, bus.ppu_count, bus.tile_idx); end
        rst = 1'b0;
        run_job(1'b0, 8'd1, 1'b0, 1'b0);
        vectors++; if (done_cyc !== 58 || n_weight !== 16 || n_arr !== 4 || n_beats !== 8) begin
            miscompares++; $display("FAIL midrst/rerun got done=%0d weight=%0d arr=%0d beats=%0d want 58,16,4,8",
                                     done_cyc, n_weight, n_arr, n_beats); end
        vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL midrst/per_cycle got %0d errors want 0", addr_err); end
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.num_tiles = '0; bus.glb_ready = 1'b1;
        force_va = 1'b0; force_vp = 1'b0;
        test_reset();
        test_single_tile();
        test_ready_stall();
        test_weight_reuse();
        test_zero_tiles();
        test_ignore_while_busy();
        test_reset_mid_array();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, which is the feature/channel width.
REQ-002 SHALL have parameter ARRAY_TIMES, default 16, which is the number of array passes per tile.
REQ-003 SHALL have parameter ADDR_W, default 12, which is the GLB address width.
REQ-004 SHALL have parameter TILE_W, default 8, which is the tile-count width.
REQ-005 SHALL derive local constants: IFMAP_WORDS=WIDTH/4, WEIGHT_WORDS=WIDTH*WIDTH/4, BIAS_WORDS=WIDTH, STG_W=$clog2(ARRAY_TIMES), PPU_W=$clog2(WIDTH+1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: begin a job; accepted only in IDLE or DONE.
REQ-009 SHALL have port mode, input, 1 bit: 1 = weight reuse (weights/bias loaded only for tile 0); sampled on accepted start.
REQ-010 SHALL have port num_tiles, input, TILE_W bits: tiles per job; sampled on accepted start; 0 is treated as 1.
REQ-011 SHALL have port glb_ready, input, 1 bit: GLB accepts a write this cycle.
REQ-012 SHALL have output ports ifmap_wen, weight_wen, bias_wen, 1 bit each: GLB write strobes.
REQ-013 SHALL have output ports ifmap_ren, weight_ren, bias_ren, 1 bit each: GLB read enables for the array.
REQ-014 SHALL have output port ofmap_ren, 1 bit: GLB ofmap read enable.
REQ-015 SHALL have output port data_address, ADDR_W bits: GLB address.
REQ-016 SHALL have output port i_en_array, 1 bit: one-cycle pass-start pulse to the array.
REQ-017 SHALL have input port valid_array, 1 bit: array pass complete.
REQ-018 SHALL have output port compute_stage, STG_W bits: index of the current pass.
REQ-019 SHALL have output port i_en_ppu, 1 bit: PPU input-valid.
REQ-020 SHALL have input port valid_ppu, 1 bit: PPU output beat.
REQ-021 SHALL have output port ppu_count, PPU_W bits: count of valid_ppu beats in the current tile.
REQ-022 SHALL have output port tile_idx, TILE_W bits: index of the current tile.
REQ-023 SHALL have output ports busy and done, 1 bit each: busy is high when the state is not IDLE/DONE; done is high in DONE.

Function
REQ-024 SHALL implement states IDLE, LD_IFMAP, LD_WEIGHT, LD_BIAS, ARRAY, PPU, NEXT_TILE, DONE; the state is registered.
REQ-025 SHALL transition IDLE/DONE -> LD_IFMAP on start, clearing tile_idx and latching mode and num_tiles.
REQ-026 SHALL, in each LD_x state, assert x_wen=glb_ready and increment data_address only when glb_ready=1; a glb_ready low-stall holds the address and the state.
REQ-027 SHALL exit a load state on the cycle the last word (address N-1, glb_ready=1) is written, and SHALL clear data_address to 0 on every state change.
REQ-028 SHALL transition LD_IFMAP -> LD_WEIGHT, except when latched mode=1 and tile_idx>0, in which case it SHALL go to ARRAY; LD_WEIGHT SHALL go to LD_BIAS; LD_BIAS SHALL go to ARRAY.
REQ-029 SHALL, in ARRAY, hold ifmap_ren/weight_ren/bias_ren=1 and data_address={compute_stage, zero-extended}.
REQ-030 SHALL pulse i_en_array on the first ARRAY cycle and again the cycle after each valid_array, except after the last valid_array.
REQ-031 SHALL increment compute_stage on valid_array in ARRAY only; after the ARRAY_TIMES-th valid_array it SHALL wrap to 0 and the FSM SHALL go to PPU.
REQ-032 SHALL, in PPU, assert ofmap_ren while data_address<WIDTH, incrementing data_address by 1 per cycle and stopping at WIDTH-1.
REQ-033 SHALL drive i_en_ppu as ofmap_ren delayed one cycle (GLB read latency 1).
REQ-034 SHALL increment ppu_count on valid_ppu in PPU; valid_ppu with ppu_count==WIDTH-1 SHALL go to NEXT_TILE; ppu_count SHALL clear outside PPU.
REQ-035 SHALL make NEXT_TILE last exactly one cycle: if tile_idx==effective_tiles-1, go to DONE with tile_idx held; else tile_idx+1 and go to LD_IFMAP.
REQ-036 SHALL ignore valid_array outside ARRAY, valid_ppu outside PPU, and start while busy.
REQ-037 SHALL hold all strobes low in IDLE, NEXT_TILE and DONE.

Reset
REQ-038 SHALL, on rst=1 at a clock edge (including mid-job), force state=IDLE and all outputs, counters, tile_idx and latched mode/num_tiles to 0; i_en_ppu SHALL be 0 in the first cycle after reset.

Verification
REQ-039 SHALL cover: WIDTH=8, ARRAY_TIMES=4, num_tiles=1, mode=0, glb_ready=1 -> exactly 2 ifmap_wen, 16 weight_wen and 8 bias_wen cycles; 4 i_en_array pulses; 8 ofmap_ren cycles; done after 8 valid_ppu.
REQ-040 SHALL cover: glb_ready toggling 1,0,1,0 during LD_WEIGHT -> data_address advances only on ready cycles; exactly 16 weight_wen.
REQ-041 SHALL cover: num_tiles=3, mode=1 -> weight_wen/bias_wen occur only while tile_idx=0; tile_idx sequence 0,1,2; done held afterward.
REQ-042 SHALL cover: num_tiles=0 -> behaves as a single tile.
REQ-043 SHALL cover: rst asserted in ARRAY at compute_stage=2 -> the next cycle has state IDLE with all outputs 0; a new start then runs a full job correctly.
REQ-044 SHALL cover: start asserted while busy, and valid_array/valid_ppu asserted in LD states -> no effect on state, counters or tile_idx.
